fft_rot_mix: RTL

FFT_ROT_MIX -- requirements
Module: fft_rot_mix

---
 rtl/fft_pkg.sv | 17 +
 rtl/fft_skid_buf.sv | 70 +++++++
 rtl/fft_rot_mix.sv | 96 +++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Constants and types shared by the FFT lane-mixing, butterfly and address blocks.
package fft_pkg;

  localparam int DEF_BIT   = 17;
  localparam int DEF_LANES = 4;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_t;

  function automatic int sel_width(input int lanes);
    return $clog2(lanes);
  endfunction

endpackage

// File: rtl/fft_skid_buf.sv
// Two-entry skid buffer: an output register plus one skid slot, with a registered ready.
module fft_skid_buf
  import fft_pkg::*;
#(
  parameter int W = 2 * DEF_LANES * DEF_BIT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_state_t  state;
  logic [W-1:0] skid_data;
  logic         accept;
  logic         drain;

  assign accept = in_valid && in_ready;
  assign drain  = out_valid && out_ready;

  // in_ready and out_valid track (state != TWO) and (state != EMPTY) as registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SKID_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      skid_data <= '0;
    end else begin
      case (state)
        SKID_EMPTY: begin
          if (accept) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            state     <= SKID_ONE;
          end
        end
        SKID_ONE: begin
          if (accept && drain) begin
            out_data <= in_data;
          end else if (accept) begin
            skid_data <= in_data;
            in_ready  <= 1'b0;
            state     <= SKID_TWO;
          end else if (drain) begin
            out_valid <= 1'b0;
            state     <= SKID_EMPTY;
          end
        end
        SKID_TWO: begin
          if (drain) begin
            out_data <= skid_data;
            in_ready <= 1'b1;
            state    <= SKID_ONE;
          end
        end
        default: begin
          state     <= SKID_EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/fft_rot_mix.sv
// Lane rotation mixer: rotates packed complex lanes by an external or auto-incrementing
// amount, then buffers the result behind a two-entry skid buffer.
module fft_rot_mix
  import fft_pkg::*;
#(
  parameter int  BIT   = DEF_BIT,
  parameter int  LANES = DEF_LANES,
  localparam int SW    = sel_width(LANES)
) (
  input  logic                 iCLK,
  input  logic                 iRESET,
  input  logic                 iVALID,
  output logic                 oREADY,
  input  logic [LANES*BIT-1:0] iX_RE,
  input  logic [LANES*BIT-1:0] iX_IM,
  input  logic [SW-1:0]        iSEL,
  input  logic                 iDIR,
  input  logic                 iAUTO,
  input  logic                 iSTART,
  output logic                 oVALID,
  input  logic                 iREADY,
  output logic [LANES*BIT-1:0] oY_RE,
  output logic [LANES*BIT-1:0] oY_IM
);

  localparam int PW = 2 * LANES * BIT;

  logic          accept;
  logic [SW-1:0] cnt;
  logic [SW-1:0] rot;
  logic [PW-1:0] payload;
  logic [PW-1:0] out_payload;

  // SW-bit index arithmetic gives the mod-LANES wrap for free
  function automatic logic [LANES*BIT-1:0] rotate(input logic [LANES*BIT-1:0] x,
                                                  input logic [SW-1:0]        r,
                                                  input logic                 dir);
    logic [LANES*BIT-1:0] y;
    logic [SW-1:0]        src;
    y = '0;
    for (int k = 0; k < LANES; k++) begin
      if (dir) begin
        src = SW'(k) - r;
      end else begin
        src = SW'(k) + r;
      end
      y[k*BIT +: BIT] = x[src*BIT +: BIT];
    end
    return y;
  endfunction

  assign accept = iVALID && oREADY;

  // Effective rotation; a start beat always uses rotation 0 in auto mode
  always_comb begin
    if (!iAUTO) begin
      rot = iSEL;
    end else if (iSTART) begin
      rot = '0;
    end else begin
      rot = cnt;
    end
  end

  // Rotation counter advances only on accepted beats
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      cnt <= '0;
    end else if (accept) begin
      if (iSTART) begin
        cnt <= SW'(1);
      end else begin
        cnt <= cnt + SW'(1);
      end
    end
  end

  assign payload = {rotate(iX_RE, rot, iDIR), rotate(iX_IM, rot, iDIR)};

  fft_skid_buf #(
    .W(PW)
  ) u_skid (
    .clk      (iCLK),
    .rst_n    (iRESET),
    .in_valid (iVALID),
    .in_ready (oREADY),
    .in_data  (payload),
    .out_valid(oVALID),
    .out_ready(iREADY),
    .out_data (out_payload)
  );

  assign oY_RE = out_payload[PW-1 -: LANES*BIT];
  assign oY_IM = out_payload[LANES*BIT-1:0];

endmodule
